i2s_sample_tx: RTL and testbench

Stereo I2S transmit stage between the RPi sample receiver and the DAC pins. It accepts parallel left/right sample pairs over a valid/ready handshake and buffers them in a small FIFO. It then serialises them MSB-first in Philips I2S format, generating sclk and lr_clk internally from the system clock. A level interrupt tells the RPi when the FIFO needs refilling.

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/sample_fifo.sv | 57 +++++
 rtl/i2s_sample_tx.sv | 114 +++++++++++
 tb/tb_i2s_sample_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

   // Default sample width; the transmitter can be parameterised away from it.
   localparam int DEF_SAMPLE_W = 16;

   // Bits in one stereo frame (left word followed by right word).
   localparam int FRAME_W = 2 * DEF_SAMPLE_W;

   // Word-select levels on lr_clk.
   localparam logic LR_LEFT  = 1'b0;
   localparam logic LR_RIGHT = 1'b1;

   // One stereo pair at the default width; left sits in the upper half so the
   // packed value is already in MSB-first transmit order.
   typedef struct packed {
      logic [DEF_SAMPLE_W-1:0] left;
      logic [DEF_SAMPLE_W-1:0] right;
   } pair_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO of stereo pairs with occupancy count.
// Latency: a pushed entry is visible at the head on the next clk.
// Backpressure: push ignored when full, pop ignored when empty.
module sample_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_dat,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_dat,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/i2s_sample_tx.sv
// Buffers stereo pairs and serialises them as Philips I2S with internal sclk/lr_clk.
// Latency: a buffered pair starts on the next frame boundary; left MSB one sclk after lr_clk falls.
// Backpressure: in_ready drops when the FIFO is full; an empty FIFO at frame start sends zeros.
module i2s_sample_tx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W   = DEF_SAMPLE_W,
   parameter int FIFO_DEPTH = 8,
   parameter int BCLK_HALF  = 2,
   parameter int LOW_WATER  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [SAMPLE_W-1:0]           in_left,
   input  logic [SAMPLE_W-1:0]           in_right,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          irq,
   output logic                          underrun,
   output logic                          sclk,
   output logic                          lr_clk,
   output logic                          serial
);

   localparam int FW    = 2 * SAMPLE_W;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int BIT_W = $clog2(FW);

   localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(BCLK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FW - 1);
   localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SAMPLE_W);
   localparam logic [CW-1:0]    LOW_CNT   = CW'(LOW_WATER);

   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [BIT_W-1:0] bit_nxt;
   logic [FW-1:0]    shreg;
   logic [FW-1:0]    fifo_dat;
   logic [FW-1:0]    frame_dat;
   logic             dly_bit;
   logic             tc;
   logic             fall;
   logic             frame_start;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;

   assign tc          = (div_cnt == DIV_TC);
   assign fall        = tc && sclk;
   assign bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
   assign frame_start = fall && (bit_cnt == BIT_LAST);
   assign fifo_pop    = frame_start && !fifo_empty;
   assign frame_dat   = fifo_empty ? '0 : fifo_dat;
   assign in_ready    = !fifo_full;
   assign irq         = (fill_level <= LOW_CNT);

   sample_fifo #(
      .DATA_W (FW),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (in_valid),
      .push_dat ({in_left, in_right}),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fill_level)
   );

   // Bit-clock divider: sclk toggles every BCLK_HALF clk cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (tc) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Bit position, word select and data shifter, all advanced on sclk falling events.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt  <= BIT_LAST;
         lr_clk   <= LR_RIGHT;
         serial   <= 1'b0;
         shreg    <= '0;
         dly_bit  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= frame_start && fifo_empty;
         if (fall) begin
            bit_cnt <= bit_nxt;
            lr_clk  <= (bit_nxt < BIT_RIGHT) ? LR_LEFT : LR_RIGHT;
            if (frame_start) begin
               // Previous right LSB goes out in slot 0: the one-bit I2S delay.
               serial  <= dly_bit;
               shreg   <= frame_dat;
               dly_bit <= frame_dat[0];
            end else begin
               serial <= shreg[FW-1];
               shreg  <= {shreg[FW-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_sample_tx.sv
module tb_i2s_sample_tx;
   import i2s_pkg::*;

   localparam int SW    = 16;
   localparam int DEPTH = 4;
   localparam int BH    = 2;
   localparam int LW    = 2;
   localparam int FW    = FRAME_W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SW-1:0] in_left;
   logic [SW-1:0] in_right;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    fill_level;
   logic          irq;
   logic          underrun;
   logic          sclk;
   logic          lr_clk;
   logic          serial;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i2s_sample_tx #(
      .SAMPLE_W   (SW),
      .FIFO_DEPTH (DEPTH),
      .BCLK_HALF  (BH),
      .LOW_WATER  (LW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_left    (in_left),
      .in_right   (in_right),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .fill_level (fill_level),
      .irq        (irq),
      .underrun   (underrun),
      .sclk       (sclk),
      .lr_clk     (lr_clk),
      .serial     (serial)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [31:0] exp_q[$];
   logic [31:0] cap = '0;
   logic [31:0] cur_exp = '0;
   pair_t       pend_pair;
   bit          pend = 1'b0;
   bit          have_frame = 1'b0;
   bit          rst_seen = 1'b1;
   bit          exp_under;
   logic        sclk_prev = 1'b0;
   int          bc = FW - 1;

   always @(posedge clk) rst_seen = rst;

   always @(negedge clk) begin
      if (rst_seen) begin
         exp_q.delete();
         bc         = FW - 1;
         have_frame = 1'b0;
         cap        = '0;
      end else begin
         exp_under = 1'b0;
         if (sclk_prev && !sclk) begin
            bc = (bc + 1) % FW;
            chk("lr_clk", 32'(lr_clk), 32'(bc >= SW));
            cap = {cap[30:0], serial};
            if (bc == 0) begin
               if (have_frame) chk("frame", cap, cur_exp);
               if (exp_q.size() > 0) begin
                  cur_exp = exp_q.pop_front();
               end else begin
                  cur_exp   = '0;
                  exp_under = 1'b1;
               end
               have_frame = 1'b1;
            end
         end
         chk("underrun", 32'(underrun), 32'(exp_under));
         if (pend) exp_q.push_back(pend_pair);
         chk("fill_level", 32'(fill_level), 32'(exp_q.size()));
         chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
         chk("irq", 32'(irq), 32'(exp_q.size() <= LW));
      end
      pend            = in_valid && in_ready;
      pend_pair.left  = in_left;
      pend_pair.right = in_right;
      sclk_prev       = sclk;
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_left  = l;
      in_right = r;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_fill(input int lvl);
      bit hit = 1'b0;
      for (int k = 0; k < 400 && !hit; k++) begin
         @(posedge clk);
         #1;
         if (fill_level == 3'(lvl)) hit = 1'b1;
      end
      if (!hit) chk("wait_fill_timeout", 32'(fill_level), 32'(lvl));
   endtask

   initial begin
      bit hit;
      in_valid = 1'b0;
      in_left  = '0;
      in_right = '0;
      rst      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sclk", 32'(sclk), 32'(0));
      chk("rst_lr", 32'(lr_clk), 32'(1));
      chk("rst_serial", 32'(serial), 32'(0));
      chk("rst_underrun", 32'(underrun), 32'(0));
      chk("rst_fill", 32'(fill_level), 32'(0));
      chk("rst_ready", 32'(in_ready), 32'(1));
      chk("rst_irq", 32'(irq), 32'(1));

      // release reset and offer one pair before the first fall
      rst      = 1'b0;
      in_valid = 1'b1;
      in_left  = 16'hA5F0;
      in_right = 16'h0F0F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("sclk_e1", 32'(sclk), 32'(0));
      chk("fill_e1", 32'(fill_level), 32'(1));
      @(posedge clk); #1;
      chk("sclk_e2", 32'(sclk), 32'(1));
      @(posedge clk); #1;
      chk("sclk_e3", 32'(sclk), 32'(1));
      @(posedge clk); #1;
      chk("sclk_e4", 32'(sclk), 32'(0));
      chk("lr_e4", 32'(lr_clk), 32'(0));
      chk("fill_e4", 32'(fill_level), 32'(0));

      // data frame then an underrun frame
      repeat (2 * FW * 2 * BH + 8) @(posedge clk);
      #1;

      // align just after a frame start with the FIFO empty
      hit = 1'b0;
      for (int k = 0; k < 300 && !hit; k++) begin
         @(posedge clk);
         #1;
         if (underrun) hit = 1'b1;
      end
      if (!hit) chk("wait_underrun_timeout", 32'(0), 32'(1));

      // fill to full with no frame start in between
      for (int i = 1; i <= 4; i++) begin
         send(16'(i), 16'(16'h8000 | i));
         if (i == 3) begin
            chk("fill3_level", 32'(fill_level), 32'(3));
            chk("fill3_irq", 32'(irq), 32'(0));
         end
      end
      chk("full_ready", 32'(in_ready), 32'(0));
      chk("full_fill", 32'(fill_level), 32'(4));
      send(16'd5, 16'h8005);
      chk("after5_fill", 32'(fill_level), 32'(4));

      // drain to low water, then push back above it
      wait_fill(2);
      chk("low_irq", 32'(irq), 32'(1));
      send(16'd6, 16'h8006);
      chk("refill_fill", 32'(fill_level), 32'(3));
      chk("refill_irq", 32'(irq), 32'(0));

      // reset mid-frame at bit 10 with two pairs buffered
      hit = 1'b0;
      for (int k = 0; k < 600 && !hit; k++) begin
         @(negedge clk);
         #1;
         if (bc == 10 && exp_q.size() == 2) hit = 1'b1;
      end
      if (!hit) chk("wait_bc10_timeout", 32'(0), 32'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_sclk", 32'(sclk), 32'(0));
      chk("mid_rst_lr", 32'(lr_clk), 32'(1));
      chk("mid_rst_serial", 32'(serial), 32'(0));
      chk("mid_rst_fill", 32'(fill_level), 32'(0));
      chk("mid_rst_ready", 32'(in_ready), 32'(1));
      rst = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
         @(posedge clk);
         #1;
         if (underrun) hit = 1'b1;
      end
      chk("post_rst_underrun", 32'(hit), 32'(1));
      repeat (2 * FW * 2 * BH + 8) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
